// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin arbiter sharing one req/gnt resource among N
// requesters. Grants are registered and one-hot. A holder that keeps its
// request beyond MAX_HOLD consecutive grant cycles while someone else waits
// is pre-empted. Handshake and fairness rules are checked by embedded
// concurrent assertions.
module rr_req_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 preempt
);

  localparam int IDW   = $clog2(N);
  localparam int HCW   = $clog2(MAX_HOLD + 1);
  localparam int BOUND = (N - 1) * MAX_HOLD + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

  logic [0:0]     state_q,     state_d;
  logic [N-1:0]   gnt_q,       gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0] gnt_id_q,    gnt_id_d;
  logic           preempt_q,   preempt_d;
  logic [IDW-1:0] last_id_q,   last_id_d;
  logic [HCW-1:0] hold_cnt_q,  hold_cnt_d;

  logic [N-1:0]   holder_oh;
  logic [N-1:0]   others;
  logic [IDW:0]   pick_all;
  logic [IDW:0]   pick_oth;
  logic           do_grant;
  logic           go_idle;
  logic [IDW-1:0] win;

  // One-hot vector with a single bit set at idx.
  function automatic logic [N-1:0] to_onehot(input logic [IDW-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: scans last+1, last+2, ... wrapping, ending at last.
  // Returns {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0]   mask,
                                           input logic [IDW-1:0] last);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] pidx;
    int             p;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      p    = (int'(last) + k) % N;
      pidx = IDW'(p);
      if (!found && mask[pidx]) begin
        found = 1'b1;
        idx   = pidx;
      end
    end
    return {found, idx};
  endfunction

  // While BUSY the holder is always last_id, so excluding last_id from the
  // search keeps an expiring holder from re-winning its own slot.
  always_comb begin
    holder_oh = to_onehot(last_id_q);
    others    = req & ~holder_oh;
    pick_all  = rr_pick(req, last_id_q);
    pick_oth  = rr_pick(others, last_id_q);
  end

  // Next-state decision: new grant, release, hold extension or pre-emption.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    last_id_d   = last_id_q;
    hold_cnt_d  = hold_cnt_q;
    preempt_d   = 1'b0;
    do_grant    = 1'b0;
    go_idle     = 1'b0;
    win         = '0;

    if (state_q == ST_IDLE) begin
      if (pick_all[IDW]) begin
        do_grant = 1'b1;
        win      = pick_all[IDW-1:0];
      end
    end else begin
      if (!req[last_id_q]) begin
        // Release: hand over without an idle gap if anyone else waits.
        if (pick_oth[IDW]) begin
          do_grant = 1'b1;
          win      = pick_oth[IDW-1:0];
        end else begin
          go_idle = 1'b1;
        end
      end else if (hold_cnt_q < HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end else if (pick_oth[IDW]) begin
        // Hold expired with a contender present: forced handover.
        do_grant  = 1'b1;
        win       = pick_oth[IDW-1:0];
        preempt_d = 1'b1;
      end
      // Expired without a contender: grant kept, hold_cnt stays saturated.
    end

    if (do_grant) begin
      state_d     = ST_BUSY;
      gnt_d       = to_onehot(win);
      gnt_valid_d = 1'b1;
      gnt_id_d    = win;
      last_id_d   = win;
      hold_cnt_d  = HOLD_ONE;
    end else if (go_idle) begin
      state_d     = ST_IDLE;
      gnt_d       = '0;
      gnt_valid_d = 1'b0;
      gnt_id_d    = '0;
      hold_cnt_d  = '0;
    end
  end

  // Arbiter state and registered outputs; pointer resets to N-1 so index 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
      last_id_q   <= IDW'(N - 1);
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      preempt_q   <= preempt_d;
      last_id_q   <= last_id_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign preempt   = preempt_q;

  // Per-requester waiting time, only feeding the starvation assertion.
  logic [31:0] wait_q [N];
  logic [31:0] wait_d [N];

  // A requester waits while its req is high and it does not hold the grant.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wait_d[i] = '0;
      if (req[i] && !gnt_q[i]) begin
        wait_d[i] = wait_q[i] + 32'd1;
      end
    end
  end

  // Waiting-time counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(gnt_q));

  a_gnt_valid: assert property (@(posedge clk) disable iff (!reset_n)
    gnt_valid_q == (|gnt_q));

  a_hold_limit: assert property (@(posedge clk) disable iff (!reset_n)
    (gnt_valid_q && (hold_cnt_q == HOLD_MAX) && (|(req & ~gnt_q)))
      |=> (gnt_q != $past(gnt_q)));

  a_hold_range: assert property (@(posedge clk) disable iff (!reset_n)
    hold_cnt_q <= HOLD_MAX);

  for (genvar g = 0; g < N; g++) begin : g_req_chk
    a_gnt_rise: assert property (@(posedge clk) disable iff (!reset_n)
      $rose(gnt_q[g]) |-> $past(req[g]));

    a_no_starve: assert property (@(posedge clk) disable iff (!reset_n)
      wait_q[g] <= 32'(BOUND));
  end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter: directed scenarios with literal expectations,
// then randomized request traffic checked every cycle against a
// behavioural model of the round-robin rules.
module tb_rr_req_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW      = $clog2(N);
  localparam int BOUND    = (N - 1) * MAX_HOLD + 1;

  logic           clk     = 1'b0;
  logic           reset_n = 1'b1;
  logic [N-1:0]   req     = '0;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  int checks   = 0;
  int failures = 0;

  // Model: who holds the resource (-1 none), last granted index,
  // length of the current grant, and whether the last edge was a pre-emption.
  int   m_holder;
  int   m_last;
  int   m_cnt;
  logic m_preempt;
  int   wait_cnt [N];

  rr_req_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .preempt  (preempt)
  );

  always #5 clk = ~clk;

  function automatic logic bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_holder  = -1;
    m_last    = N - 1;
    m_cnt     = 0;
    m_preempt = 1'b0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // First requester with req high, scanning the ring starting just after m_last.
  function automatic int m_pick(input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (bitof(mask, (m_last + k) % N)) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_holder = w;
    m_last   = w;
    m_cnt    = 1;
  endtask

  // Advance the model by one clock edge using the req seen at that edge.
  task automatic model_step();
    int w;
    logic [N-1:0] contenders;
    m_preempt = 1'b0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_holder < 0) begin
      w = m_pick(req);
      if (w >= 0) m_grant(w);
    end else begin
      contenders = req & ~(N'(1) << m_holder);
      if (!bitof(req, m_holder)) begin
        w = m_pick(contenders);
        if (w >= 0) m_grant(w);
        else begin
          m_holder = -1;
          m_cnt    = 0;
        end
      end else if (m_cnt < MAX_HOLD) begin
        m_cnt++;
      end else begin
        w = m_pick(contenders);
        if (w >= 0) begin
          m_grant(w);
          m_preempt = 1'b1;
        end
      end
    end
  endtask

  // Compare every output against the model, plus the starvation bound.
  task automatic compare_all();
    logic [N-1:0] exp_gnt;
    exp_gnt = (m_holder < 0) ? '0 : (N'(1) << m_holder);
    check("gnt",       int'(gnt),       int'(exp_gnt));
    check("gnt_valid", int'(gnt_valid), (m_holder >= 0) ? 1 : 0);
    check("gnt_id",    int'(gnt_id),    (m_holder >= 0) ? m_holder : 0);
    check("preempt",   int'(preempt),   int'(m_preempt));
    for (int i = 0; i < N; i++) begin
      if (bitof(req, i) && !bitof(gnt, i)) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > 0) check("starve_bound", (wait_cnt[i] <= BOUND) ? 1 : 0, 1);
    end
  endtask

  // One cycle: drive req, let the edge happen, compare on the falling edge.
  task automatic tick(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Assert reset at a falling edge, check outputs clear at once, hold 2 cycles.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_gnt",       int'(gnt),       0);
    check("rst_gnt_valid", int'(gnt_valid), 0);
    check("rst_gnt_id",    int'(gnt_id),    0);
    check("rst_preempt",   int'(preempt),   0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    check(name, act, exp);
  endtask

  logic [N-1:0] r;

  initial begin
    model_reset();
    @(negedge clk);

    // Single requester
    do_reset();
    tick(4'b0000);
    for (int c = 0; c < 3; c++) begin
      tick(4'b0001);
      lit("single_gnt", int'(gnt), 4'b0001);
      lit("single_id", int'(gnt_id), 0);
      lit("single_pre", int'(preempt), 0);
    end
    tick(4'b0000);
    lit("single_drop", int'(gnt), 0);
    lit("single_drop_valid", int'(gnt_valid), 0);

    // All four requesting: rotation 0,1,2,3,0 with MAX_HOLD-cycle slots
    do_reset();
    for (int t = 0; t < 40; t++) begin
      tick(4'b1111);
      lit("rot_id", int'(gnt_id), (t / MAX_HOLD) % N);
      lit("rot_pre", int'(preempt), (t > 0 && (t % MAX_HOLD) == 0) ? 1 : 0);
    end

    // Voluntary release with requester 2 pending
    do_reset();
    tick(4'b0101);
    lit("vol_first", int'(gnt), 4'b0001);
    tick(4'b0101);
    lit("vol_hold", int'(gnt), 4'b0001);
    tick(4'b0100);
    lit("vol_hand", int'(gnt), 4'b0100);
    lit("vol_valid", int'(gnt_valid), 1);
    lit("vol_pre", int'(preempt), 0);

    // Lone holder beyond MAX_HOLD keeps the grant
    do_reset();
    for (int t = 0; t < 20; t++) begin
      tick(4'b0010);
      lit("lone_gnt", int'(gnt), 4'b0010);
      lit("lone_pre", int'(preempt), 0);
    end
    tick(4'b0000);

    // Pointer wrap from last_id=3: requester 0 first, then 3 after expiry
    do_reset();
    for (int t = 0; t < 9; t++) begin
      tick(4'b1001);
      lit("wrap_gnt", int'(gnt), (t < MAX_HOLD) ? 4'b0001 : 4'b1000);
    end
    lit("wrap_pre", int'(preempt), 1);

    // Reset in the middle of a grant
    do_reset();
    tick(4'b0100);
    tick(4'b0100);
    lit("mid_gnt", int'(gnt), 4'b0100);
    req = 4'b1111;
    do_reset();
    tick(4'b1111);
    lit("post_rst_gnt", int'(gnt), 4'b0001);
    lit("post_rst_id", int'(gnt_id), 0);

    // Randomized traffic: sticky request bits, rare resets
    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) r = r ^ (N'(1) << i);
      end
      if ($urandom_range(0, 999) == 0) begin
        req = r;
        do_reset();
      end
      tick(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
